mc_ctrl: RTL and testbench
==========================

// Module: mc_ctrl
// PURPOSE
//  Main control FSM of the multicycle MIPS CPU; sits directly upstream of the ALU and drives ALUOp
//  plus every datapath mux/write-enable each cycle. Decodes Op/Funct held in IR, sequences
//  FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, consumes ALU Zero for branches. Moore FSM; one clock.
// PARAMETERS
//  RA_IDX    5'd31   register index written by jal
//  SHAMT_EN  1       1: sll/srl take shamt on ALU A input; 0: sll/srl decode as illegal
// PORTS
//  clk       in   1   system clock, rising edge
//  rst       in   1   reset, synchronous, active-high
//  Op        in   6   IR[31:26]
//  Funct     in   6   IR[5:0]
//  Zero      in   1   ALU Zero, valid in BRANCH
//  PCWrite   out  1   PC write enable
//  IRWrite   out  1   IR load enable
//  IorD      out  1   mem addr: 0=PC, 1=ALUOut
//  MemWrite  out  1   data memory write enable
//  RegWrite  out  1   register file write enable
//  RegDst    out  2   0=rt, 1=rd, 2=RA_IDX
//  WDSel     out  2   0=ALUOut, 1=MDR, 2=PC (return address)
//  ALUSrcA   out  2   0=PC, 1=regA, 2=shamt zero-extended
//  ALUSrcB   out  2   0=regB, 1=32'd4, 2=ext imm, 3=ext imm<<2
//  EXTOp     out  1   1=sign-extend imm, 0=zero-extend (andi/ori)
//  ALUOp     out  4   ALU operation, `ALU_* encoding
//  NPCOp     out  2   PC source: 0=ALU result, 1=ALUOut (branch tgt), 2=jump tgt, 3=regA (jr)
//  Illegal   out  1   1-cycle pulse in DECODE on unsupported Op/Funct
// BEHAVIOUR
//  States: FETCH, DECODE, EXE_R, EXE_I, MEM_ADR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP.
//  Outputs decoded from registered state (+Op/Funct/Zero); unlisted outputs = 0 in every state.
//  FETCH: IRWrite=1, PCWrite=1, ALUSrcA=0, ALUSrcB=1, ALUOp=ADD, NPCOp=0 -> DECODE.
//  DECODE: ALUSrcA=0, ALUSrcB=3, EXTOp=1, ALUOp=ADD (branch target to ALUOut). Next:
//   R-type(Op=0) & jr -> JUMP; other R-type -> EXE_R; lw/sw -> MEM_ADR; beq/bne -> BRANCH;
//   addi/andi/ori/slti/sltiu/lui -> EXE_I; j/jal -> JUMP; else Illegal=1 -> FETCH.
//  EXE_R: ALUSrcA=1 (2 for sll/srl), ALUSrcB=0; ALUOp per Funct: addu/add=ADD, subu/sub=SUB,
//   and, or, nor, slt, sltu, sll, srl, sllv, srlv -> matching `ALU_* -> WB_ALU.
//  EXE_I: ALUSrcA=1, ALUSrcB=2, EXTOp=0 for andi/ori else 1; ALUOp ADD/AND/OR/SLT/SLTU/LUI -> WB_ALU.
//  WB_ALU: RegWrite=1, WDSel=0, RegDst=1 if R-type else 0 -> FETCH.
//  MEM_ADR: ALUSrcA=1, ALUSrcB=2, EXTOp=1, ALUOp=ADD -> MEM_RD (lw) / MEM_WR (sw).
//  MEM_RD: IorD=1 -> WB_MEM.  WB_MEM: RegWrite=1, RegDst=0, WDSel=1 -> FETCH.
//  MEM_WR: IorD=1, MemWrite=1 -> FETCH.
//  BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=SUB, NPCOp=1; PCWrite = Zero (beq) / ~Zero (bne) -> FETCH.
//  JUMP: PCWrite=1, NPCOp=2 (j/jal) or 3 (jr); jal also RegWrite=1, RegDst=2, WDSel=2 -> FETCH.
//  Latency (cycles): lw 5; R/I-type, sw 4; beq/bne, j, jal, jr 3; illegal 2 (no writes).
//  Reset: rst high at edge -> state=FETCH. While rst=1 all enables (PCWrite, IRWrite, MemWrite,
//   RegWrite) forced 0, Illegal=0, muxes=0, ALUOp=`ALU_NOP. Reset mid-instruction abandons it;
//   no partial write issues on the reset cycle.
//  Zero sampled only in BRANCH; ignored elsewhere. Op/Funct read only in DECODE..WB (IR stable).
//  Unreachable state encodings -> FETCH next cycle, outputs as for rst.
// STRUCTURE
//  Shared in ctrl_encode_def.v: `ALU_* codes, state encodings, NPC_*/WD_*/RD_*/SRCA_*/SRCB_* codes,
//   Op/Funct constants.
//  One sub-module: mc_ctrl_dec (combinational Op/Funct -> instr class + ALUOp); FSM stays here.
// TESTING
//  addu $3,$1,$2 -> 4 cycles; EXE_R ALUOp=`ALU_ADD; WB_ALU RegWrite=1, RegDst=1, WDSel=0.
//  lw $2,8($1) -> 5 cycles; MEM_ADR ALUSrcB=2; MEM_RD IorD=1; WB_MEM RegWrite=1, WDSel=1.
//  beq with Zero=1 -> BRANCH PCWrite=1, NPCOp=1; Zero=0 -> PCWrite=0; bne inverts; 3 cycles each.
//  jal -> JUMP PCWrite=1, NPCOp=2, RegWrite=1, RegDst=2, WDSel=2; jr -> NPCOp=3, RegWrite=0.
//  Op=6'h3F -> Illegal=1 for one cycle in DECODE, back to FETCH, no enable asserted.
//  rst=1 during MEM_WR cycle -> MemWrite=0 that cycle, state=FETCH next; sll: ALUSrcA=2, ALUOp=SLL.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: ALU codes, mux selects,
// opcode/funct constants, FSM states and the decoder payload.
package mc_ctrl_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned ALUOP_W = 4;
    localparam int unsigned SEL_W   = 2;

    // Register index the datapath writes for jal when RegDst selects RD_RA.
    localparam logic [4:0] RA_IDX = 5'd31;

    localparam logic [ALUOP_W-1:0] ALU_NOP  = 4'd0;
    localparam logic [ALUOP_W-1:0] ALU_ADD  = 4'd1;
    localparam logic [ALUOP_W-1:0] ALU_SUB  = 4'd2;
    localparam logic [ALUOP_W-1:0] ALU_AND  = 4'd3;
    localparam logic [ALUOP_W-1:0] ALU_OR   = 4'd4;
    localparam logic [ALUOP_W-1:0] ALU_NOR  = 4'd5;
    localparam logic [ALUOP_W-1:0] ALU_SLT  = 4'd6;
    localparam logic [ALUOP_W-1:0] ALU_SLTU = 4'd7;
    localparam logic [ALUOP_W-1:0] ALU_SLL  = 4'd8;
    localparam logic [ALUOP_W-1:0] ALU_SRL  = 4'd9;
    localparam logic [ALUOP_W-1:0] ALU_SLLV = 4'd10;
    localparam logic [ALUOP_W-1:0] ALU_SRLV = 4'd11;
    localparam logic [ALUOP_W-1:0] ALU_LUI  = 4'd12;

    localparam logic [SEL_W-1:0] NPC_ALU    = 2'd0;
    localparam logic [SEL_W-1:0] NPC_ALUOUT = 2'd1;
    localparam logic [SEL_W-1:0] NPC_JUMP   = 2'd2;
    localparam logic [SEL_W-1:0] NPC_REGA   = 2'd3;

    localparam logic [SEL_W-1:0] WD_ALUOUT = 2'd0;
    localparam logic [SEL_W-1:0] WD_MDR    = 2'd1;
    localparam logic [SEL_W-1:0] WD_PC     = 2'd2;

    localparam logic [SEL_W-1:0] RD_RT = 2'd0;
    localparam logic [SEL_W-1:0] RD_RD = 2'd1;
    localparam logic [SEL_W-1:0] RD_RA = 2'd2;

    localparam logic [SEL_W-1:0] SRCA_PC    = 2'd0;
    localparam logic [SEL_W-1:0] SRCA_REGA  = 2'd1;
    localparam logic [SEL_W-1:0] SRCA_SHAMT = 2'd2;

    localparam logic [SEL_W-1:0] SRCB_REGB    = 2'd0;
    localparam logic [SEL_W-1:0] SRCB_FOUR    = 2'd1;
    localparam logic [SEL_W-1:0] SRCB_IMM     = 2'd2;
    localparam logic [SEL_W-1:0] SRCB_IMM_SL2 = 2'd3;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OP_W-1:0] OP_SLTIU = 6'h0B;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [OP_W-1:0] F_SLL  = 6'h00;
    localparam logic [OP_W-1:0] F_SRL  = 6'h02;
    localparam logic [OP_W-1:0] F_SLLV = 6'h04;
    localparam logic [OP_W-1:0] F_SRLV = 6'h06;
    localparam logic [OP_W-1:0] F_JR   = 6'h08;
    localparam logic [OP_W-1:0] F_ADD  = 6'h20;
    localparam logic [OP_W-1:0] F_ADDU = 6'h21;
    localparam logic [OP_W-1:0] F_SUB  = 6'h22;
    localparam logic [OP_W-1:0] F_SUBU = 6'h23;
    localparam logic [OP_W-1:0] F_AND  = 6'h24;
    localparam logic [OP_W-1:0] F_OR   = 6'h25;
    localparam logic [OP_W-1:0] F_NOR  = 6'h27;
    localparam logic [OP_W-1:0] F_SLT  = 6'h2A;
    localparam logic [OP_W-1:0] F_SLTU = 6'h2B;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_EXE_R   = 4'd2,
        S_EXE_I   = 4'd3,
        S_MEM_ADR = 4'd4,
        S_MEM_RD  = 4'd5,
        S_MEM_WR  = 4'd6,
        S_WB_ALU  = 4'd7,
        S_WB_MEM  = 4'd8,
        S_BRANCH  = 4'd9,
        S_JUMP    = 4'd10
    } state_e;

    typedef enum logic [3:0] {
        C_R, C_JR, C_LW, C_SW, C_BEQ, C_BNE, C_I, C_J, C_JAL, C_ILL
    } icls_e;

    typedef struct packed {
        icls_e               icls;
        logic [ALUOP_W-1:0]  aluop;
        logic                shamt;
        logic                zext;
    } dec_t;

endpackage

// File: rtl/mc_ctrl_dec.sv
// Combinational instruction decode: Op/Funct -> instruction class, ALU operation,
// shift-amount source and immediate extension mode.
module mc_ctrl_dec
    import mc_ctrl_pkg::*;
#(
    parameter bit SHAMT_EN = 1'b1
) (
    input  logic [OP_W-1:0] op,
    input  logic [OP_W-1:0] funct,
    output dec_t            dec_c
);

    always_comb begin
        dec_c = '{icls: C_ILL, aluop: ALU_NOP, shamt: 1'b0, zext: 1'b0};
        case (op)
            OP_RTYPE: begin
                dec_c.icls = C_R;
                case (funct)
                    F_ADD, F_ADDU: dec_c.aluop = ALU_ADD;
                    F_SUB, F_SUBU: dec_c.aluop = ALU_SUB;
                    F_AND:         dec_c.aluop = ALU_AND;
                    F_OR:          dec_c.aluop = ALU_OR;
                    F_NOR:         dec_c.aluop = ALU_NOR;
                    F_SLT:         dec_c.aluop = ALU_SLT;
                    F_SLTU:        dec_c.aluop = ALU_SLTU;
                    F_SLLV:        dec_c.aluop = ALU_SLLV;
                    F_SRLV:        dec_c.aluop = ALU_SRLV;
                    F_JR:          dec_c.icls  = C_JR;
                    // Immediate shifts need the shamt path on ALU A.
                    F_SLL, F_SRL: begin
                        if (SHAMT_EN) begin
                            dec_c.aluop = (funct == F_SLL) ? ALU_SLL : ALU_SRL;
                            dec_c.shamt = 1'b1;
                        end else begin
                            dec_c.icls = C_ILL;
                        end
                    end
                    default:       dec_c.icls  = C_ILL;
                endcase
            end
            OP_LW:    begin dec_c.icls = C_LW;  dec_c.aluop = ALU_ADD; end
            OP_SW:    begin dec_c.icls = C_SW;  dec_c.aluop = ALU_ADD; end
            OP_BEQ:   begin dec_c.icls = C_BEQ; dec_c.aluop = ALU_SUB; end
            OP_BNE:   begin dec_c.icls = C_BNE; dec_c.aluop = ALU_SUB; end
            OP_ADDI:  begin dec_c.icls = C_I;   dec_c.aluop = ALU_ADD; end
            OP_SLTI:  begin dec_c.icls = C_I;   dec_c.aluop = ALU_SLT; end
            OP_SLTIU: begin dec_c.icls = C_I;   dec_c.aluop = ALU_SLTU; end
            OP_ANDI:  begin dec_c.icls = C_I;   dec_c.aluop = ALU_AND; dec_c.zext = 1'b1; end
            OP_ORI:   begin dec_c.icls = C_I;   dec_c.aluop = ALU_OR;  dec_c.zext = 1'b1; end
            OP_LUI:   begin dec_c.icls = C_I;   dec_c.aluop = ALU_LUI; end
            OP_J:     dec_c.icls = C_J;
            OP_JAL:   dec_c.icls = C_JAL;
            default:  dec_c.icls = C_ILL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Main control FSM of the multicycle MIPS CPU. Datapath controls are decoded from
// the registered state so BRANCH can react to the ALU Zero flag in the same cycle.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter bit SHAMT_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OP_W-1:0]    Op,
    input  logic [OP_W-1:0]    Funct,
    input  logic               Zero,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic               IorD,
    output logic               MemWrite,
    output logic               RegWrite,
    output logic [SEL_W-1:0]   RegDst,
    output logic [SEL_W-1:0]   WDSel,
    output logic [SEL_W-1:0]   ALUSrcA,
    output logic [SEL_W-1:0]   ALUSrcB,
    output logic               EXTOp,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [SEL_W-1:0]   NPCOp,
    output logic               Illegal
);

    state_e state;
    dec_t   dec_c;

    mc_ctrl_dec #(.SHAMT_EN(SHAMT_EN)) u_dec (
        .op    (Op),
        .funct (Funct),
        .dec_c (dec_c)
    );

    // State sequencing; unreachable encodings fall back to FETCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:  state <= S_DECODE;
                S_DECODE: begin
                    case (dec_c.icls)
                        C_R:              state <= S_EXE_R;
                        C_I:              state <= S_EXE_I;
                        C_LW, C_SW:       state <= S_MEM_ADR;
                        C_BEQ, C_BNE:     state <= S_BRANCH;
                        C_JR, C_J, C_JAL: state <= S_JUMP;
                        default:          state <= S_FETCH;
                    endcase
                end
                S_EXE_R, S_EXE_I: state <= S_WB_ALU;
                S_MEM_ADR: state <= (dec_c.icls == C_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:  state <= S_WB_MEM;
                default:   state <= S_FETCH;
            endcase
        end
    end

    // Per-state control decode; reset and unknown states leave everything idle.
    always_comb begin
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        IorD     = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        RegDst   = RD_RT;
        WDSel    = WD_ALUOUT;
        ALUSrcA  = SRCA_PC;
        ALUSrcB  = SRCB_REGB;
        EXTOp    = 1'b0;
        ALUOp    = ALU_NOP;
        NPCOp    = NPC_ALU;
        Illegal  = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    ALUOp   = ALU_ADD;
                end
                S_DECODE: begin
                    ALUSrcB = SRCB_IMM_SL2;
                    EXTOp   = 1'b1;
                    ALUOp   = ALU_ADD;
                    Illegal = (dec_c.icls == C_ILL);
                end
                S_EXE_R: begin
                    ALUSrcA = dec_c.shamt ? SRCA_SHAMT : SRCA_REGA;
                    ALUOp   = dec_c.aluop;
                end
                S_EXE_I: begin
                    ALUSrcA = SRCA_REGA;
                    ALUSrcB = SRCB_IMM;
                    EXTOp   = ~dec_c.zext;
                    ALUOp   = dec_c.aluop;
                end
                S_WB_ALU: begin
                    RegWrite = 1'b1;
                    RegDst   = (Op == OP_RTYPE) ? RD_RD : RD_RT;
                end
                S_MEM_ADR: begin
                    ALUSrcA = SRCA_REGA;
                    ALUSrcB = SRCB_IMM;
                    EXTOp   = 1'b1;
                    ALUOp   = ALU_ADD;
                end
                S_MEM_RD: IorD = 1'b1;
                S_WB_MEM: begin
                    RegWrite = 1'b1;
                    WDSel    = WD_MDR;
                end
                S_MEM_WR: begin
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA = SRCA_REGA;
                    ALUOp   = ALU_SUB;
                    NPCOp   = NPC_ALUOUT;
                    PCWrite = (dec_c.icls == C_BNE) ? ~Zero : Zero;
                end
                S_JUMP: begin
                    PCWrite = 1'b1;
                    NPCOp   = (dec_c.icls == C_JR) ? NPC_REGA : NPC_JUMP;
                    if (dec_c.icls == C_JAL) begin
                        RegWrite = 1'b1;
                        RegDst   = RD_RA;
                        WDSel    = WD_PC;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks instructions cycle by cycle and compares the
// full control vector against hand-derived per-state expectations.
module tb_mc_ctrl;

    localparam logic [3:0] A_NOP  = 4'd0;
    localparam logic [3:0] A_ADD  = 4'd1;
    localparam logic [3:0] A_SUB  = 4'd2;
    localparam logic [3:0] A_AND  = 4'd3;
    localparam logic [3:0] A_OR   = 4'd4;
    localparam logic [3:0] A_NOR  = 4'd5;
    localparam logic [3:0] A_SLT  = 4'd6;
    localparam logic [3:0] A_SLTU = 4'd7;
    localparam logic [3:0] A_SLL  = 4'd8;
    localparam logic [3:0] A_SRL  = 4'd9;
    localparam logic [3:0] A_SLLV = 4'd10;
    localparam logic [3:0] A_LUI  = 4'd12;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Op, Funct;
    logic       Zero;
    logic       PCWrite, IRWrite, IorD, MemWrite, RegWrite, EXTOp, Illegal;
    logic [1:0] RegDst, WDSel, ALUSrcA, ALUSrcB, NPCOp;
    logic [3:0] ALUOp;
    logic [20:0] ctl;

    int n_checks = 0;
    int n_pass   = 0;

    logic [20:0] e_fetch, e_decode, e_wb_r, e_wb_i, e_madr;

    mc_ctrl dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .RegDst(RegDst), .WDSel(WDSel), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .EXTOp(EXTOp), .ALUOp(ALUOp), .NPCOp(NPCOp), .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    assign ctl = {PCWrite, IRWrite, IorD, MemWrite, RegWrite, RegDst, WDSel,
                  ALUSrcA, ALUSrcB, EXTOp, ALUOp, NPCOp, Illegal};

    function automatic logic [20:0] ctl_f(
        input logic pcw, input logic irw, input logic iord, input logic memw,
        input logic regw, input logic [1:0] rd, input logic [1:0] wd,
        input logic [1:0] sa, input logic [1:0] sb, input logic ext,
        input logic [3:0] alu, input logic [1:0] npc, input logic ill);
        return {pcw, irw, iord, memw, regw, rd, wd, sa, sb, ext, alu, npc, ill};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Sample mid-cycle, then advance to just after the next rising edge.
    task automatic step(input string tag, input logic [20:0] exp);
        @(negedge clk);
        check(tag, 32'(ctl), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic start(input string tag, input logic [5:0] op, input logic [5:0] fn,
                         input logic z);
        Op = op; Funct = fn; Zero = z;
        step({tag, "_fetch"}, e_fetch);
    endtask

    task automatic instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                         input logic z);
        start(tag, op, fn, z);
        step({tag, "_decode"}, e_decode);
    endtask

    task automatic rtype(input string tag, input logic [5:0] fn, input logic [1:0] sa,
                         input logic [3:0] alu);
        instr(tag, 6'h00, fn, 1'b1);
        step({tag, "_exe"}, ctl_f(0,0,0,0,0, 2'd0,2'd0, sa,2'd0, 0, alu, 2'd0, 0));
        step({tag, "_wb"}, e_wb_r);
    endtask

    task automatic itype(input string tag, input logic [5:0] op, input logic ext,
                         input logic [3:0] alu);
        instr(tag, op, 6'h2A, 1'b0);
        step({tag, "_exe"}, ctl_f(0,0,0,0,0, 2'd0,2'd0, 2'd1,2'd2, ext, alu, 2'd0, 0));
        step({tag, "_wb"}, e_wb_i);
    endtask

    task automatic branch(input string tag, input logic [5:0] op, input logic z,
                          input logic pcw);
        instr(tag, op, 6'h00, z);
        step({tag, "_br"}, ctl_f(pcw,0,0,0,0, 2'd0,2'd0, 2'd1,2'd0, 0, A_SUB, 2'd1, 0));
    endtask

    initial begin
        e_fetch  = ctl_f(1,1,0,0,0, 2'd0,2'd0, 2'd0,2'd1, 0, A_ADD, 2'd0, 0);
        e_decode = ctl_f(0,0,0,0,0, 2'd0,2'd0, 2'd0,2'd3, 1, A_ADD, 2'd0, 0);
        e_wb_r   = ctl_f(0,0,0,0,1, 2'd1,2'd0, 2'd0,2'd0, 0, A_NOP, 2'd0, 0);
        e_wb_i   = ctl_f(0,0,0,0,1, 2'd0,2'd0, 2'd0,2'd0, 0, A_NOP, 2'd0, 0);
        e_madr   = ctl_f(0,0,0,0,0, 2'd0,2'd0, 2'd1,2'd2, 1, A_ADD, 2'd0, 0);

        rst = 1'b1; Op = 6'h00; Funct = 6'h21; Zero = 1'b0;
        @(posedge clk);
        #1;
        step("reset_idle", 21'd0);
        rst = 1'b0;

        rtype("addu", 6'h21, 2'd1, A_ADD);
        rtype("sub",  6'h22, 2'd1, A_SUB);
        rtype("nor",  6'h27, 2'd1, A_NOR);
        rtype("sltu", 6'h2B, 2'd1, A_SLTU);
        rtype("sllv", 6'h04, 2'd1, A_SLLV);
        rtype("sll",  6'h00, 2'd2, A_SLL);
        rtype("srl",  6'h02, 2'd2, A_SRL);

        itype("addi", 6'h08, 1'b1, A_ADD);
        itype("andi", 6'h0C, 1'b0, A_AND);
        itype("ori",  6'h0D, 1'b0, A_OR);
        itype("slti", 6'h0A, 1'b1, A_SLT);
        itype("lui",  6'h0F, 1'b1, A_LUI);

        instr("lw", 6'h23, 6'h08, 1'b1);
        step("lw_adr", e_madr);
        step("lw_rd",  ctl_f(0,0,1,0,0, 2'd0,2'd0, 2'd0,2'd0, 0, A_NOP, 2'd0, 0));
        step("lw_wb",  ctl_f(0,0,0,0,1, 2'd0,2'd1, 2'd0,2'd0, 0, A_NOP, 2'd0, 0));

        instr("sw", 6'h2B, 6'h08, 1'b0);
        step("sw_adr", e_madr);
        step("sw_wr",  ctl_f(0,0,1,1,0, 2'd0,2'd0, 2'd0,2'd0, 0, A_NOP, 2'd0, 0));

        branch("beq_taken", 6'h04, 1'b1, 1'b1);
        branch("beq_not",   6'h04, 1'b0, 1'b0);
        branch("bne_taken", 6'h05, 1'b0, 1'b1);
        branch("bne_not",   6'h05, 1'b1, 1'b0);

        instr("j", 6'h02, 6'h00, 1'b0);
        step("j_jump",   ctl_f(1,0,0,0,0, 2'd0,2'd0, 2'd0,2'd0, 0, A_NOP, 2'd2, 0));
        instr("jal", 6'h03, 6'h00, 1'b0);
        step("jal_jump", ctl_f(1,0,0,0,1, 2'd2,2'd2, 2'd0,2'd0, 0, A_NOP, 2'd2, 0));
        instr("jr", 6'h00, 6'h08, 1'b0);
        step("jr_jump",  ctl_f(1,0,0,0,0, 2'd0,2'd0, 2'd0,2'd0, 0, A_NOP, 2'd3, 0));

        start("ill_op", 6'h3F, 6'h00, 1'b0);
        step("ill_op_decode", ctl_f(0,0,0,0,0, 2'd0,2'd0, 2'd0,2'd3, 1, A_ADD, 2'd0, 1));
        start("ill_fn", 6'h00, 6'h3F, 1'b0);
        step("ill_fn_decode", ctl_f(0,0,0,0,0, 2'd0,2'd0, 2'd0,2'd3, 1, A_ADD, 2'd0, 1));

        // Reset lands on the store's memory-write cycle; no write may escape.
        instr("sw_rst", 6'h2B, 6'h00, 1'b0);
        step("sw_rst_adr", e_madr);
        rst = 1'b1;
        step("sw_rst_wr", 21'd0);
        rst = 1'b0;

        rtype("post_rst_and", 6'h24, 2'd1, A_AND);
        start("final", 6'h00, 6'h00, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
